acc_sequencer: RTL

- Multi-cycle accumulator execution unit; the initiator side of the existing combinational Alu module (op=0: A+B; op=1: A+~B+1; co=1 on sub means no borrow).
- Accepts commands over valid/ready, drives the Alu port one pass per cycle and captures res/co.
- Performs 2W-bit wide add/sub by chaining W-bit passes with an optional carry-fix pass, since the Alu's carry-in is hardwired to op.
- Returns accumulator and flags over a valid/ready response channel.

---
 rtl/acc_pkg.sv | 18 +
 rtl/acc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// acc_sequencer shared definitions.
// Command opcodes and the sequencer state encoding.
package acc_pkg;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_SUB  = 2'd2;
   localparam logic [1:0] OP_CMP  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_FIX,
      ST_RESP
   } state_t;

endpackage

// File: rtl/acc_sequencer.sv
// Accumulator sequencer driving an external W-bit Alu.
// Wide ops chain LO/HI passes plus an optional carry-fix pass.
module acc_sequencer
   import acc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic         cmd_wide,
   input  logic [2*W-1:0] cmd_data,
   output logic         alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_res,
   input  logic         alu_co,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [2*W-1:0] rsp_acc,
   output logic         rsp_c,
   output logic         rsp_z
);

   state_t         r_state;
   logic [1:0]     r_op;
   logic           r_wide;
   logic [W-1:0]   r_data_hi;
   logic [2*W-1:0] r_acc;
   logic           r_c;
   logic           r_z;
   logic [W-1:0]   r_lo;
   logic           r_co_lo;
   logic           r_co_hi;
   logic           r_alu_op;
   logic [W-1:0]   r_alu_a;
   logic [W-1:0]   r_alu_b;
   logic           r_rsp_valid;

   logic           w_fix_need;
   logic           w_wb_go;
   logic [W-1:0]   w_res_lo;
   logic [2*W-1:0] w_res;
   logic           w_res_c;
   logic           w_res_z;

   assign cmd_ready = (r_state == ST_IDLE);
   assign alu_op    = r_alu_op;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign rsp_valid = r_rsp_valid;
   assign rsp_acc   = r_acc;
   assign rsp_c     = r_c;
   assign rsp_z     = r_z;

   // Alu carry-in is fixed to op, so a lo-pass carry/borrow needs a fix pass.
   always_comb begin
      w_fix_need = (r_op == OP_ADD) ? r_co_lo : !r_co_lo;
      w_wb_go    = 1'b0;
      w_res_lo   = r_lo;
      w_res_c    = alu_co;
      unique case (r_state)
         ST_LO: begin
            w_res_lo = alu_res;
            w_wb_go  = !r_wide;
         end
         ST_HI: begin
            w_wb_go = !w_fix_need;
         end
         ST_FIX: begin
            w_wb_go = 1'b1;
            w_res_c = (r_op == OP_ADD) ? (r_co_hi | alu_co)
                                       : (r_co_hi & alu_co);
         end
         default: begin
            w_wb_go = 1'b0;
         end
      endcase
      if (r_wide) begin
         w_res   = {alu_res, w_res_lo};
         w_res_z = (w_res == '0);
      end else begin
         w_res   = {r_acc[2*W-1:W], w_res_lo};
         w_res_z = (w_res_lo == '0);
      end
   end

   // Sequencer FSM: accept, run Alu passes, write back, hold response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_LOAD;
         r_wide      <= 1'b0;
         r_data_hi   <= '0;
         r_acc       <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b1;
         r_lo        <= '0;
         r_co_lo     <= 1'b0;
         r_co_hi     <= 1'b0;
         r_alu_op    <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op      <= cmd_op;
                  r_wide    <= cmd_wide;
                  r_data_hi <= cmd_data[2*W-1:W];
                  if (cmd_op == OP_LOAD) begin
                     if (cmd_wide) begin
                        r_acc <= cmd_data;
                        r_z   <= (cmd_data == '0);
                     end else begin
                        r_acc[W-1:0] <= cmd_data[W-1:0];
                        r_z          <= (cmd_data[W-1:0] == '0);
                     end
                     r_c         <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_alu_op <= (cmd_op != OP_ADD);
                     r_alu_a  <= r_acc[W-1:0];
                     r_alu_b  <= cmd_data[W-1:0];
                     r_state  <= ST_LO;
                  end
               end
            end
            ST_LO: begin
               r_lo    <= alu_res;
               r_co_lo <= alu_co;
               if (r_wide) begin
                  r_alu_a <= r_acc[2*W-1:W];
                  r_alu_b <= r_data_hi;
                  r_state <= ST_HI;
               end
            end
            ST_HI: begin
               r_co_hi <= alu_co;
               if (w_fix_need) begin
                  r_alu_a <= alu_res;
                  r_alu_b <= W'(1);
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (w_wb_go) begin
            if (r_op != OP_CMP) r_acc <= w_res;
            r_c         <= w_res_c;
            r_z         <= w_res_z;
            r_alu_op    <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
         end
      end
   end

endmodule
